hs_npu_gate_chain: RTL and testbench

HS_NPU_GATE_CHAIN -- requirements
Module: hs_npu_gate_chain

---
 rtl/hs_npu_pkg.sv | 13 +
 rtl/hs_npu_fifo.sv | 74 +++++++
 rtl/hs_npu_gate_chain.sv | 159 +++++++++++++++
 tb/tb_hs_npu_gate_chain.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_npu_pkg.sv
// Shared types for the hs_npu blocks: the common unsigned word and the gate-chain FSM states.
package hs_npu_pkg;

  typedef logic [31:0] uword;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } gate_chain_state_t;

endpackage

// File: rtl/hs_npu_fifo.sv
// Small first-word-fall-through FIFO; a push is also accepted while full when a pop happens in the same cycle.
module hs_npu_fifo
  import hs_npu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign rdata_o = mem[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/hs_npu_gate_chain.sv
// Buffers vector beats and releases a counted run through a per-lane skew triangle.
// Define HS_NPU_GATE_CHAIN_ZERO_FILL_EN to drive invalid lanes as zero instead of holding data.
module hs_npu_gate_chain
  import hs_npu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANES = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk_core,
  input  logic                         rst_core_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES-1:0][WIDTH-1:0]  in_data,
  input  logic                         start_i,
  input  uword                         enable_cycles,
  output logic [LANES-1:0][WIDTH-1:0]  out_data,
  output logic [LANES-1:0]             out_lane_valid,
  output logic                         start_o,
  output logic                         busy,
  output logic                         done
);

  localparam int DCW = $clog2(LANES) + 1;
  localparam logic [DCW-1:0] DRAIN_LEN = DCW'(LANES - 1);

  gate_chain_state_t state_q, state_d;
  uword              cnt_q, cnt_d;
  logic [DCW-1:0]    drain_q, drain_d;
  logic              first_seen_q, first_seen_d;

  logic                        fifo_full, fifo_empty;
  logic [LANES*WIDTH-1:0]      fifo_rdata;
  logic [LANES-1:0][WIDTH-1:0] pop_beat;
  logic                        pop, push;

  // in_ready reports occupancy only; a pop frees the slot a same-cycle push uses.
  assign pop      = (state_q == RUN) && !fifo_empty && !flush;
  assign push     = in_valid && !flush && (!fifo_full || pop);
  assign in_ready = !fifo_full;
  assign pop_beat = fifo_rdata;

  hs_npu_fifo #(
    .WIDTH (LANES * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk_core),
    .rst_n   (rst_core_n),
    .clr_i   (flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_data),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      drain_q      <= '0;
      first_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      drain_q      <= drain_d;
      first_seen_q <= first_seen_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    drain_d      = drain_q;
    first_seen_d = first_seen_q | out_lane_valid[LANES-1];
    if (flush) begin
      state_d      = IDLE;
      cnt_d        = '0;
      drain_d      = '0;
      first_seen_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          first_seen_d = 1'b0;
          if (start_i) begin
            cnt_d   = enable_cycles;
            state_d = (enable_cycles != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (pop && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == uword'(1)) begin
              state_d = (LANES > 1) ? DRAIN : DONE;
              drain_d = DRAIN_LEN;
            end
          end
        end
        DRAIN: begin
          if (drain_q > DCW'(1)) begin
            drain_d = drain_q - 1'b1;
          end else begin
            drain_d = '0;
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    start_o = out_lane_valid[LANES-1] && !first_seen_q;
  end

  // Lane gi is a chain of gi+1 stages; data stages load only on valid so the tail holds its last element.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [WIDTH-1:0] dat_q [gi+1];
    logic [WIDTH-1:0] dat_d [gi+1];
    logic [gi:0]      vld_q, vld_d;

    always_comb begin
      vld_d = vld_q;
      for (int s = 0; s <= gi; s++) dat_d[s] = dat_q[s];
      vld_d[0] = pop;
      if (pop) dat_d[0] = pop_beat[gi];
      for (int s = 1; s <= gi; s++) begin
        vld_d[s] = vld_q[s-1];
        if (vld_q[s-1]) dat_d[s] = dat_q[s-1];
      end
      if (flush) begin
        vld_d = '0;
        for (int s = 0; s <= gi; s++) dat_d[s] = '0;
      end
    end

    always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) begin
        vld_q <= '0;
        for (int s = 0; s <= gi; s++) dat_q[s] <= '0;
      end else begin
        vld_q <= vld_d;
        for (int s = 0; s <= gi; s++) dat_q[s] <= dat_d[s];
      end
    end

    assign out_lane_valid[gi] = vld_q[gi];
`ifdef HS_NPU_GATE_CHAIN_ZERO_FILL_EN
    assign out_data[gi] = vld_q[gi] ? dat_q[gi] : '0;
`else
    assign out_data[gi] = dat_q[gi];
`endif
  end

endmodule

// File: tb/tb_hs_npu_gate_chain.sv
// Scoreboard bench for hs_npu_gate_chain: stimulus queues expected lane elements, a monitor pops and compares.
module tb_hs_npu_gate_chain;

  localparam int WIDTH = 32;
  localparam int LANES = 4;
  localparam int DEPTH = 4;

  typedef logic [LANES-1:0][WIDTH-1:0] beat_t;

  logic        clk_core = 1'b0;
  logic        rst_core_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  beat_t       in_data;
  logic        start_i;
  logic [31:0] enable_cycles;
  beat_t       out_data;
  logic [LANES-1:0] out_lane_valid;
  logic        start_o;
  logic        busy;
  logic        done;

  always #5 clk_core = ~clk_core;

  hs_npu_gate_chain #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk_core       (clk_core),
    .rst_core_n     (rst_core_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .start_i        (start_i),
    .enable_cycles  (enable_cycles),
    .out_data       (out_data),
    .out_lane_valid (out_lane_valid),
    .start_o        (start_o),
    .busy           (busy),
    .done           (done)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cs    = 0;

  logic [WIDTH-1:0] lane_q [LANES][$];
  beat_t            model_fifo [$];
  int               rem_run = 0;

  int l0_cyc [$];
  int l3_cyc [$];
  int lane_cnt [LANES];
  int start_cnt, done_cnt, busy_cnt, start_cyc, done_cyc;

  always @(posedge clk_core) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every valid lane element is matched against the head of that lane's queue.
  initial begin
    forever begin
      @(negedge clk_core);
      for (int k = 0; k < LANES; k++) begin
        if (out_lane_valid[k]) begin
          lane_cnt[k]++;
          if (lane_q[k].size() == 0)
            check($sformatf("lane%0d_unexpected_valid", k), out_lane_valid[k], 1'b0);
          else
            check($sformatf("lane%0d_data", k), out_data[k], lane_q[k].pop_front());
        end
      end
      if (out_lane_valid[0]) l0_cyc.push_back(cyc);
      if (out_lane_valid[LANES-1]) l3_cyc.push_back(cyc);
      if (start_o) begin
        start_cnt++;
        start_cyc = cyc;
        check("start_o_with_last_lane", out_lane_valid[LANES-1], 1'b1);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic clear_stats();
    for (int k = 0; k < LANES; k++) lane_cnt[k] = 0;
    start_cnt = 0; done_cnt = 0; busy_cnt = 0;
    start_cyc = -1; done_cyc = -1;
    l0_cyc.delete();
    l3_cyc.delete();
  endtask

  task automatic clear_model();
    for (int k = 0; k < LANES; k++) lane_q[k].delete();
    model_fifo.delete();
    rem_run = 0;
  endtask

  function automatic beat_t mk_beat(input int base);
    beat_t b;
    for (int k = 0; k < LANES; k++) b[k] = WIDTH'(base + k);
    return b;
  endfunction

  task automatic model_push(input beat_t b);
    if (rem_run > 0) begin
      for (int k = 0; k < LANES; k++) lane_q[k].push_back(b[k]);
      rem_run--;
    end else begin
      model_fifo.push_back(b);
    end
  endtask

  task automatic push_beat(input int base);
    in_data  = mk_beat(base);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    model_push(mk_beat(base));
  endtask

  task automatic start_run(input int n);
    beat_t b;
    start_i       = 1'b1;
    enable_cycles = n;
    tick();
    start_i = 1'b0;
    cs      = cyc;
    rem_run = n;
    while (rem_run > 0 && model_fifo.size() > 0) begin
      b = model_fifo.pop_front();
      for (int k = 0; k < LANES; k++) lane_q[k].push_back(b[k]);
      rem_run--;
    end
  endtask

  task automatic wait_done(input string p, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == 0) check({p, "_done_timeout"}, done, 1'b1);
    tick();
    tick();
  endtask

  // Two beats, run of 2: lane0 at cs+1/cs+2, lane3 three cycles later, done with lane3's last.
  task automatic run_normal(input string p);
    clear_stats();
    push_beat(1);
    push_beat(5);
    start_run(2);
    wait_done(p, 40);
    check({p, "_done_cnt"}, done_cnt, 1);
    check({p, "_start_o_cnt"}, start_cnt, 1);
    check({p, "_busy_cycles"}, busy_cnt, 6);
    for (int k = 0; k < LANES; k++) check($sformatf("%s_lane%0d_cnt", p, k), lane_cnt[k], 2);
    check({p, "_l0_first_cyc"}, l0_cyc[0], cs + 1);
    check({p, "_l0_second_cyc"}, l0_cyc[1], cs + 2);
    check({p, "_l3_first_cyc"}, l3_cyc[0], cs + 4);
    check({p, "_l3_second_cyc"}, l3_cyc[1], cs + 5);
    check({p, "_start_o_cyc"}, start_cyc, cs + 4);
    check({p, "_done_cyc"}, done_cyc, cs + 5);
  endtask

  initial begin
    rst_core_n    = 1'b0;
    flush         = 1'b0;
    in_valid      = 1'b0;
    in_data       = '0;
    start_i       = 1'b0;
    enable_cycles = '0;
    clear_stats();
    clear_model();

    #12;
    check("rst_out_lane_valid", out_lane_valid, '0);
    check("rst_out_data", out_data, '0);
    check("rst_start_o", start_o, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    tick();
    rst_core_n = 1'b1;
    tick();

    run_normal("normal");

    // Underflow: one beat buffered, two more arrive five cycles into the run.
    clear_stats();
    push_beat(9);
    start_run(3);
    repeat (5) tick();
    push_beat(13);
    push_beat(17);
    wait_done("underflow", 40);
    for (int k = 0; k < LANES; k++) check($sformatf("underflow_lane%0d_cnt", k), lane_cnt[k], 3);
    check("underflow_l0_cyc0", l0_cyc[0], cs + 1);
    check("underflow_l0_cyc1", l0_cyc[1], cs + 7);
    check("underflow_l0_cyc2", l0_cyc[2], cs + 8);
    check("underflow_done_cnt", done_cnt, 1);
    check("underflow_done_cyc", done_cyc, cs + 11);
    check("underflow_start_o_cyc", start_cyc, cs + 4);
    check("underflow_busy_cycles", busy_cnt, 12);

    // Zero-length run goes straight to DONE.
    clear_stats();
    start_run(0);
    repeat (3) tick();
    check("zero_done_cnt", done_cnt, 1);
    check("zero_done_cyc", done_cyc, cs);
    check("zero_start_o_cnt", start_cnt, 0);
    check("zero_busy_cycles", busy_cnt, 1);
    check("zero_lane0_cnt", lane_cnt[0], 0);
    check("zero_lane3_cnt", lane_cnt[LANES-1], 0);

    // Full buffer: push+pop while full keeps in_ready low and keeps the new beat.
    clear_stats();
    push_beat(21);
    push_beat(25);
    push_beat(29);
    check("full_ready_not_full", in_ready, 1'b1);
    push_beat(33);
    check("full_ready_full", in_ready, 1'b0);
    start_run(2);
    in_data  = mk_beat(37);
    in_valid = 1'b1;
    #1;
    check("full_ready_during_pushpop", in_ready, 1'b0);
    tick();
    in_valid = 1'b0;
    model_push(mk_beat(37));
    check("full_ready_after_pushpop", in_ready, 1'b0);
    tick();
    check("full_ready_after_second_pop", in_ready, 1'b1);
    wait_done("full_run1", 40);
    check("full_run1_lane0_cnt", lane_cnt[0], 2);
    clear_stats();
    start_run(3);
    wait_done("full_run2", 40);
    check("full_run2_lane3_cnt", lane_cnt[LANES-1], 3);
    check("full_run2_done_cnt", done_cnt, 1);

    // Flush in DRAIN, with a start and a push in the same cycle that must be ignored.
    clear_stats();
    push_beat(41);
    start_run(1);
    tick();
    flush         = 1'b1;
    start_i       = 1'b1;
    enable_cycles = 5;
    in_valid      = 1'b1;
    in_data       = mk_beat(45);
    tick();
    flush    = 1'b0;
    start_i  = 1'b0;
    in_valid = 1'b0;
    clear_model();
    check("flush_out_lane_valid", out_lane_valid, '0);
    check("flush_busy", busy, 1'b0);
    check("flush_done", done, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    repeat (8) tick();
    check("flush_done_cnt", done_cnt, 0);
    check("flush_busy_cycles", busy_cnt, 2);
    check("flush_lane0_cnt", lane_cnt[0], 1);
    check("flush_lane3_cnt", lane_cnt[LANES-1], 0);

    // Asynchronous reset mid-run, then a normal run must behave identically.
    clear_stats();
    push_beat(51);
    push_beat(55);
    start_run(2);
    #2;
    rst_core_n = 1'b0;
    #1;
    check("midrst_out_lane_valid", out_lane_valid, '0);
    check("midrst_out_data", out_data, '0);
    check("midrst_start_o", start_o, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    clear_model();
    tick();
    rst_core_n = 1'b1;
    tick();
    run_normal("after_reset");

    for (int k = 0; k < LANES; k++)
      check($sformatf("final_lane%0d_queue_left", k), lane_q[k].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
